// File: rtl/write_burst_framer.sv
// Write-path burst framer. It takes one burst length per burst and the matching
// write beats, then drives the AXI4 W channel with WLAST on the final beat.
// Each accepted length is held in an in-order queue until its B response
// arrives, and is then returned to the response FIFO. The queue occupancy is
// the number of outstanding bursts, and it limits how many new lengths are accepted.
module write_burst_framer #(
    parameter int DataWidth      = 512,
    parameter int BurstLenWidth  = 8,
    parameter int MaxOutstanding = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BurstLenWidth-1:0] burst_len_dout,
    input  logic                     burst_len_empty_n,
    output logic                     burst_len_read,
    input  logic [DataWidth-1:0]     data_dout,
    input  logic                     data_empty_n,
    output logic                     data_read,
    output logic [DataWidth-1:0]     m_axi_wdata,
    output logic [DataWidth/8-1:0]   m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [BurstLenWidth-1:0] write_resp_din,
    input  logic                     write_resp_full_n,
    output logic                     write_resp_write
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [BurstLenWidth-1:0] beat_cnt_r;
    logic [BurstLenWidth-1:0] cur_len_r;
    logic [BurstLenWidth-1:0] len_q_r [MaxOutstanding];
    logic [PtrW-1:0]          wr_ptr_r;
    logic [PtrW-1:0]          rd_ptr_r;
    logic [CntW-1:0]          occ_r;
    logic [DataWidth-1:0]     wdata_r;
    logic                     wvalid_r;
    logic                     wlast_r;
    logic                     len_rd_s;
    logic                     data_rd_s;
    logic                     last_beat_s;
    logic                     bready_s;
    logic                     pop_s;

    // Advance a circular queue pointer, wrapping at the queue depth.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return PtrW'(0);
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    assign last_beat_s = (beat_cnt_r == cur_len_r);
    assign bready_s    = (occ_r != CntW'(0)) && write_resp_full_n;
    assign pop_s       = m_axi_bvalid && bready_s;

    // FSM next state and FIFO pop requests.
    always_comb begin
        state_s   = state_r;
        len_rd_s  = 1'b0;
        data_rd_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (burst_len_empty_n && (occ_r < CntW'(MaxOutstanding))) begin
                    len_rd_s = 1'b1;
                    state_s  = DATA;
                end else begin
                    state_s  = IDLE;
                end
            end
            DATA: begin
                if (data_empty_n && (!wvalid_r || m_axi_wready)) begin
                    data_rd_s = 1'b1;
                    if (last_beat_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst tracking: latch the length and count beats. The counter stops at cur_len on the final beat, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_len_r  <= {BurstLenWidth{1'b0}};
            beat_cnt_r <= {BurstLenWidth{1'b0}};
        end else if (len_rd_s) begin
            cur_len_r  <= burst_len_dout;
            beat_cnt_r <= {BurstLenWidth{1'b0}};
        end else if (data_rd_s && !last_beat_s) begin
            beat_cnt_r <= beat_cnt_r + BurstLenWidth'(1);
        end
    end

    // W channel output register: load on a data pop, hold while stalled, and drop valid after an unreplaced handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_r  <= {DataWidth{1'b0}};
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
        end else if (data_rd_s) begin
            wdata_r  <= data_dout;
            wvalid_r <= 1'b1;
            wlast_r  <= last_beat_s;
        end else if (m_axi_wready) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
        end
    end

    // Outstanding-length queue storage, written at the tail on each length pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                len_q_r[i] <= {BurstLenWidth{1'b0}};
            end
        end else if (len_rd_s) begin
            len_q_r[wr_ptr_r] <= burst_len_dout;
        end
    end

    // Queue pointers and occupancy. Occupancy is unchanged on a simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PtrW'(0);
            rd_ptr_r <= PtrW'(0);
            occ_r    <= CntW'(0);
        end else begin
            if (len_rd_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({len_rd_s, pop_s})
                2'b10:   occ_r <= occ_r + CntW'(1);
                2'b01:   occ_r <= occ_r - CntW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign burst_len_read   = len_rd_s;
    assign data_read        = data_rd_s;
    assign m_axi_wdata      = wdata_r;
    assign m_axi_wstrb      = {(DataWidth/8){1'b1}};
    assign m_axi_wlast      = wlast_r;
    assign m_axi_wvalid     = wvalid_r;
    assign m_axi_bready     = bready_s;
    assign write_resp_write = pop_s;
    assign write_resp_din   = len_q_r[rd_ptr_r];

endmodule
